dffram_bist: RTL and testbench
==============================

# dffram_bist

Built-in self-test controller that drives the single-port DFFRAM macro interface (CLK, WE0, EN0, A0, Di0, Do0) as its initiator. It runs a March C- algorithm over every word of the 256x32 array, compares read data against expected values, and reports pass/fail with the first failing address and data. It sits between the SoC RAM port mux and the macro; the mux selects this block while `busy` is high.

## Interface
Parameters:
- `AW`, 8, address width (2^AW words)
- `DW`, 32, data width; WE0 width is DW/8
- `PATTERN`, 32'h0000_0000, background word; "0" writes PATTERN, "1" writes ~PATTERN

Ports:
- `CLK`  in  1  clock; all state changes on the rising edge
- `RST`  in  1  synchronous reset, active-high
- `start`  in  1  begin test; sampled only in IDLE or DONE
- `busy`  out  1  test in progress
- `done`  out  1  test finished; level, held until next start or RST
- `fail`  out  1  mismatch detected; valid when done=1
- `fail_elem`  out  3  march element (0–5) of the first mismatch
- `fail_addr`  out  AW  address of the first mismatch
- `fail_data`  out  DW  raw Do0 at the first mismatch
- `WE0`  out  DW/8  byte write enables to RAM
- `EN0`  out  1  RAM enable
- `A0`  out  AW  RAM address
- `Di0`  out  DW  RAM write data
- `Do0`  in  DW  RAM read data, valid the cycle after a read (EN0=1, WE0=0)

## Operation
- States: IDLE, M0..M5, DRAIN, DONE.
- Elements: M0 ⇑ w0; M1 ⇑ (r0,w1); M2 ⇑ (r1,w0); M3 ⇓ (r0,w1); M4 ⇓ (r1,w0); M5 ⇑ r0. ⇑ = 0→2^AW−1, ⇓ = 2^AW−1→0.
- Write-only element: one write per cycle, WE0 all ones.
- Read+write element: cycle A reads addr (EN0=1, WE0=0); cycle B writes addr and compares Do0 against the expected value; next address's read follows in the next cycle.
- M5: one read per cycle; each read compared in the following cycle (pipelined); DRAIN is one cycle comparing the final read.
- Element transition occurs when the last address completes; no idle cycles between elements.
- Mismatch: on the first compare where Do0 ≠ expected, capture fail_elem/fail_addr/fail_data, set fail=1, and go to DONE (abort). Capture registers are not updated afterwards.
- IDLE/DONE/DRAIN: EN0=0, WE0=0, A0=0, Di0=0.
- RAM-side outputs are decoded from state/address registers only; no combinational path from `start` or `Do0` to any output.
- `start` while busy is ignored. `start` in DONE clears done/fail/captures and restarts from M0.
- RST at any point: next cycle is IDLE, all outputs 0; RAM contents are left as they are.

## Timing
- Reset values: busy=0, done=0, fail=0, fail_elem=0, fail_addr=0, fail_data=0, WE0=0, EN0=0, A0=0, Di0=0.
- Cycle 0 = cycle in which start=1 is sampled. busy=1 from cycle 1.
- AW=8: M0 cycles 1–256, M1 257–768, M2 769–1280, M3 1281–1792, M4 1793–2304, M5 2305–2560, DRAIN 2561.
- Pass: done=1, busy=0, fail=0 from cycle 2562.
- Fail: done=1, fail=1, busy=0 in the cycle after the mismatching compare cycle.
- General pass latency: 10·2^AW + 2 cycles from start to done.

## Test plan
- Fault-free behavioural RAM model, PATTERN=0: start pulse at cycle 0 -> busy cycles 1–2561, done=1, fail=0 at cycle 2562; write count = 5·256, read count = 5·256.
- Bit 5 of address 0x3C stuck at 1 -> read at cycle 377, compare at 378; at cycle 379 done=1, fail=1, fail_elem=1, fail_addr=0x3C, fail_data=0x0000_0020.
- Model ignores A0[7] (0x80 aliases 0x00) -> fail at cycle 515, fail_elem=1, fail_addr=0x80, fail_data=0xFFFF_FFFF.
- RST asserted at cycle 1000 -> at cycle 1001 busy=0, done=0, EN0=0, WE0=0; a new start then gives a full pass at start+2562.
- start re-pulsed at cycle 500 (busy) -> ignored, done still at 2562. start while in DONE after a failure -> fail cleared and the test reruns.
- PATTERN=32'hA5A5_A5A5 on the fault-free model -> M0 writes 0xA5A5A5A5, M1 writes 0x5A5A5A5A, pass at cycle 2562.

Source files
------------

// File: rtl/dffram_bist.sv
// dffram_bist: March C- self-test controller for a single-port DFFRAM macro.
// Runs M0..M5 over every word, compares read data against the expected
// background and reports the first mismatch (element, address, raw data).
//
// Control handshake: `start` is a one-cycle request that is accepted only in
// IDLE or DONE. `busy` is high from the cycle after acceptance until the test
// ends. `done` then stays high, with `fail` and the captures valid, until the
// next accepted `start` or RST.
module dffram_bist #(
   parameter int              AW      = 8,
   parameter int              DW      = 32,
   parameter logic [DW-1:0]   PATTERN = 32'h0000_0000
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              fail,
   output logic [2:0]        fail_elem,
   output logic [AW-1:0]     fail_addr,
   output logic [DW-1:0]     fail_data,
   output logic [DW/8-1:0]   WE0,
   output logic              EN0,
   output logic [AW-1:0]     A0,
   output logic [DW-1:0]     Di0,
   input  logic [DW-1:0]     Do0
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_M0,
      S_M1,
      S_M2,
      S_M3,
      S_M4,
      S_M5,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [AW-1:0] ADDR_MAX = '1;

   state_t          state, state_n;
   logic [AW-1:0]   addr, addr_n;
   logic            phase, phase_n;   // 0: read cycle, 1: write+compare cycle

   logic            descending;
   logic [AW-1:0]   last_addr;
   logic [AW-1:0]   step_addr;

   logic            cmp_valid;
   logic [DW-1:0]   cmp_exp;
   logic [AW-1:0]   cmp_addr;
   logic [2:0]      cmp_elem;
   logic            mismatch;
   logic            accept;

   // March element number reported for a given state.
   function automatic logic [2:0] elem_of(input state_t s);
      case (s)
         S_M1:           elem_of = 3'd1;
         S_M2:           elem_of = 3'd2;
         S_M3:           elem_of = 3'd3;
         S_M4:           elem_of = 3'd4;
         S_M5, S_DRAIN:  elem_of = 3'd5;
         default:        elem_of = 3'd0;
      endcase
   endfunction

   assign accept = start && ((state == S_IDLE) || (state == S_DONE));

   // Address direction for the current element: M3/M4 walk downwards.
   always_comb begin
      descending = (state == S_M3) || (state == S_M4);
      last_addr  = descending ? '0 : ADDR_MAX;
      step_addr  = descending ? addr - 1'b1 : addr + 1'b1;
   end

   // Which read result is checked this cycle, and against what.
   // M5 is pipelined, so it checks the previous address; DRAIN checks the last.
   always_comb begin
      cmp_valid = 1'b0;
      cmp_exp   = PATTERN;
      cmp_addr  = addr;
      cmp_elem  = elem_of(state);
      case (state)
         S_M1, S_M3: begin
            cmp_valid = phase;
            cmp_exp   = PATTERN;
         end
         S_M2, S_M4: begin
            cmp_valid = phase;
            cmp_exp   = ~PATTERN;
         end
         S_M5: begin
            cmp_valid = (addr != '0);
            cmp_addr  = addr - 1'b1;
         end
         S_DRAIN: begin
            cmp_valid = 1'b1;
            cmp_addr  = ADDR_MAX;
         end
         default: ;
      endcase
      mismatch = cmp_valid && (Do0 != cmp_exp);
   end

   // State, address and phase registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= S_IDLE;
         addr  <= '0;
         phase <= 1'b0;
      end else begin
         state <= state_n;
         addr  <= addr_n;
         phase <= phase_n;
      end
   end

   // Next-state logic: walk addresses per element, abort on first mismatch.
   always_comb begin
      state_n = state;
      addr_n  = addr;
      phase_n = phase;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_n = S_M0;
               addr_n  = '0;
               phase_n = 1'b0;
            end
         end
         S_M0: begin
            if (addr == ADDR_MAX) begin
               state_n = S_M1;
               addr_n  = '0;
            end else begin
               addr_n = step_addr;
            end
         end
         S_M1, S_M2, S_M3, S_M4: begin
            if (!phase) begin
               phase_n = 1'b1;
            end else begin
               phase_n = 1'b0;
               if (mismatch) begin
                  state_n = S_DONE;
               end else if (addr != last_addr) begin
                  addr_n = step_addr;
               end else begin
                  case (state)
                     S_M1: begin
                        state_n = S_M2;
                        addr_n  = '0;
                     end
                     S_M2: begin
                        state_n = S_M3;
                        addr_n  = ADDR_MAX;
                     end
                     S_M3: begin
                        state_n = S_M4;
                        addr_n  = ADDR_MAX;
                     end
                     default: begin
                        state_n = S_M5;
                        addr_n  = '0;
                     end
                  endcase
               end
            end
         end
         S_M5: begin
            if (mismatch) begin
               state_n = S_DONE;
            end else if (addr == ADDR_MAX) begin
               state_n = S_DRAIN;
            end else begin
               addr_n = step_addr;
            end
         end
         S_DRAIN: begin
            state_n = S_DONE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   // First-failure capture; cleared by reset or by an accepted start.
   always_ff @(posedge CLK) begin
      if (RST || accept) begin
         fail      <= 1'b0;
         fail_elem <= '0;
         fail_addr <= '0;
         fail_data <= '0;
      end else if (mismatch && !fail) begin
         fail      <= 1'b1;
         fail_elem <= cmp_elem;
         fail_addr <= cmp_addr;
         fail_data <= Do0;
      end
   end

   // Status and RAM-side outputs, decoded from state and address only.
   always_comb begin
      busy = (state != S_IDLE) && (state != S_DONE);
      done = (state == S_DONE);
      EN0  = 1'b0;
      WE0  = '0;
      A0   = '0;
      Di0  = '0;
      case (state)
         S_M0: begin
            EN0 = 1'b1;
            WE0 = '1;
            A0  = addr;
            Di0 = PATTERN;
         end
         S_M1, S_M3: begin
            EN0 = 1'b1;
            WE0 = phase ? '1 : '0;
            A0  = addr;
            Di0 = ~PATTERN;
         end
         S_M2, S_M4: begin
            EN0 = 1'b1;
            WE0 = phase ? '1 : '0;
            A0  = addr;
            Di0 = PATTERN;
         end
         S_M5: begin
            EN0 = 1'b1;
            A0  = addr;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_dffram_bist.sv
// tb_dffram_bist: drives two BIST instances (PATTERN 0 and A5A5A5A5) against
// behavioural RAMs, one of which can carry a planted fault. A march trace
// model predicts every cycle of bus activity and the final verdict.
`timescale 1ns/1ps
module tb_dffram_bist;

   localparam logic [31:0] PAT1 = 32'hA5A5_A5A5;

   // ---------------- clock / reset ----------------
   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   // ---------------- DUT 0 (PATTERN 0) ----------------
   logic        start_0 = 1'b0;
   logic        busy_0, done_0, fail_0, en_0;
   logic [2:0]  felem_0;
   logic [7:0]  faddr_0, a_0;
   logic [31:0] fdata_0, di_0, do_0;
   logic [3:0]  we_0;

   dffram_bist #(.AW(8), .DW(32), .PATTERN(32'h0000_0000)) u_dut (
      .CLK(CLK), .RST(RST), .start(start_0),
      .busy(busy_0), .done(done_0), .fail(fail_0),
      .fail_elem(felem_0), .fail_addr(faddr_0), .fail_data(fdata_0),
      .WE0(we_0), .EN0(en_0), .A0(a_0), .Di0(di_0), .Do0(do_0)
   );

   // ---------------- DUT 1 (PATTERN A5A5A5A5) ----------------
   logic        start_1 = 1'b0;
   logic        busy_1, done_1, fail_1, en_1;
   logic [2:0]  felem_1;
   logic [7:0]  faddr_1, a_1;
   logic [31:0] fdata_1, di_1, do_1;
   logic [3:0]  we_1;

   dffram_bist #(.AW(8), .DW(32), .PATTERN(PAT1)) u_dut_p (
      .CLK(CLK), .RST(RST), .start(start_1),
      .busy(busy_1), .done(done_1), .fail(fail_1),
      .fail_elem(felem_1), .fail_addr(faddr_1), .fail_data(fdata_1),
      .WE0(we_1), .EN0(en_1), .A0(a_1), .Di0(di_1), .Do0(do_1)
   );

   // ---------------- behavioural RAMs ----------------
   // fault_mode on RAM 0: 0 none, 1 bit 5 of word 0x3C stuck at 1,
   // 2 address bit 7 ignored (0x80 aliases 0x00).
   int          fault_mode = 0;
   logic [31:0] mem_0 [256];
   logic [31:0] mem_1 [256];
   int          wr_cnt = 0;
   int          rd_cnt = 0;

   function automatic logic [7:0] ram0_idx(input logic [7:0] a);
      return (fault_mode == 2) ? {1'b0, a[6:0]} : a;
   endfunction

   always @(posedge CLK) begin
      if (en_0) begin
         if (we_0 != 4'h0) begin
            for (int b = 0; b < 4; b++)
               if (we_0[b]) mem_0[ram0_idx(a_0)][b*8 +: 8] <= di_0[b*8 +: 8];
            wr_cnt <= wr_cnt + 1;
         end else begin
            do_0   <= mem_0[ram0_idx(a_0)] |
                      (((fault_mode == 1) && (a_0 == 8'h3C)) ? 32'h0000_0020 : 32'h0);
            rd_cnt <= rd_cnt + 1;
         end
      end
   end

   always @(posedge CLK) begin
      if (en_1) begin
         if (we_1 != 4'h0) begin
            for (int b = 0; b < 4; b++)
               if (we_1[b]) mem_1[a_1][b*8 +: 8] <= di_1[b*8 +: 8];
         end else begin
            do_1 <= mem_1[a_1];
         end
      end
   end

   // ---------------- selected-DUT view ----------------
   bit          sel = 1'b0;
   logic        cur_busy, cur_done, cur_fail, cur_en;
   logic [2:0]  cur_felem;
   logic [7:0]  cur_faddr, cur_a;
   logic [31:0] cur_fdata, cur_di;
   logic [3:0]  cur_we;

   always_comb begin
      cur_busy  = sel ? busy_1  : busy_0;
      cur_done  = sel ? done_1  : done_0;
      cur_fail  = sel ? fail_1  : fail_0;
      cur_felem = sel ? felem_1 : felem_0;
      cur_faddr = sel ? faddr_1 : faddr_0;
      cur_fdata = sel ? fdata_1 : fdata_0;
      cur_en    = sel ? en_1    : en_0;
      cur_we    = sel ? we_1    : we_0;
      cur_a     = sel ? a_1     : a_0;
      cur_di    = sel ? di_1    : di_0;
   end

   // ---------------- march trace model ----------------
   // exp_q holds one entry per busy cycle: {en, we, di_checked, addr[7:0], di[31:0]}.
   logic [42:0] exp_q[$];
   logic [31:0] mm [256];
   int          g_fault;
   bit          g_stop;
   bit          pend_v;
   logic [31:0] pend_got, pend_exp;
   logic [2:0]  pend_elem;
   logic [7:0]  pend_addr;
   bit          exp_fail;
   logic [2:0]  exp_elem;
   logic [7:0]  exp_addr;
   logic [31:0] exp_data;
   int          trace_len;

   function automatic logic [7:0] m_idx(input logic [7:0] a);
      return (g_fault == 2) ? {1'b0, a[6:0]} : a;
   endfunction

   function automatic logic [31:0] m_rd(input logic [7:0] a);
      logic [31:0] v;
      v = mm[m_idx(a)];
      if ((g_fault == 1) && (a == 8'h3C)) v = v | 32'h0000_0020;
      return v;
   endfunction

   // Append one bus cycle; a compare left pending by the previous read
   // happens in this cycle, and a mismatch ends the trace after it.
   task automatic m_push(input logic en, input logic we, input logic [7:0] a,
                         input logic [31:0] di, input logic chk);
      exp_q.push_back({en, we, chk, a, di});
      if (pend_v) begin
         pend_v = 1'b0;
         if (pend_got !== pend_exp) begin
            g_stop   = 1'b1;
            exp_fail = 1'b1;
            exp_elem = pend_elem;
            exp_addr = pend_addr;
            exp_data = pend_got;
         end
      end
   endtask

   task automatic build_trace(input logic [31:0] pat, input int fault);
      logic [7:0]  a;
      logic [31:0] rv, wv;
      exp_q.delete();
      g_fault  = fault;
      g_stop   = 1'b0;
      pend_v   = 1'b0;
      exp_fail = 1'b0;
      exp_elem = '0;
      exp_addr = '0;
      exp_data = '0;
      for (int i = 0; i < 256; i++) mm[i] = 32'hDEAD_BEEF;
      for (int e = 0; e < 6 && !g_stop; e++) begin
         for (int k = 0; k < 256 && !g_stop; k++) begin
            a  = (e == 3 || e == 4) ? 8'(255 - k) : 8'(k);
            rv = (e == 2 || e == 4) ? ~pat : pat;
            wv = (e == 1 || e == 3) ? ~pat : pat;
            if (e == 0) begin
               m_push(1'b1, 1'b1, a, wv, 1'b1);
               mm[m_idx(a)] = wv;
            end else begin
               m_push(1'b1, 1'b0, a, 32'h0, 1'b0);
               if (!g_stop) begin
                  pend_v    = 1'b1;
                  pend_got  = m_rd(a);
                  pend_exp  = rv;
                  pend_elem = 3'(e);
                  pend_addr = a;
               end
               if (e != 5 && !g_stop) begin
                  m_push(1'b1, 1'b1, a, wv, 1'b1);
                  mm[m_idx(a)] = wv;
               end
            end
         end
      end
      if (!g_stop) m_push(1'b0, 1'b0, 8'h0, 32'h0, 1'b1);
      trace_len = exp_q.size();
   endtask

   // ---------------- scoreboard ----------------
   int tests  = 0;
   int fails  = 0;
   int nshown = 0;
   int done_cycle;
   logic [31:0] lit_di1, lit_di258;

   task automatic cmp(input string name, input int cyc, input logic [90:0] exp,
                      input logic [31:0] di_mask);
      logic [90:0] got;
      got = {cur_busy, cur_done, cur_fail, cur_felem, cur_faddr, cur_fdata,
             cur_en, cur_we, cur_a, cur_di & di_mask};
      tests++;
      if (got !== exp) begin
         fails++;
         if (nshown < 20) begin
            nshown++;
            $display("FAIL %s cycle %0d: got %h, required %h", name, cyc, got, exp);
         end
      end
   endtask

   task automatic lit(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h, required %h", name, got, exp);
      end
   endtask

   task automatic drive_start(input bit v);
      if (sel) start_1 = v;
      else     start_0 = v;
   endtask

   // Pulse start, then check every busy cycle against the trace and the
   // final verdict; optionally re-pulse start or assert RST mid-run.
   task automatic run_test(input string name, input int fault, input int abort_at,
                           input int repulse_at);
      logic [42:0] e;
      logic [31:0] mask;
      build_trace(sel ? PAT1 : 32'h0, fault);
      fault_mode = sel ? 0 : fault;
      @(negedge CLK);
      drive_start(1'b1);
      for (int c = 1; c <= trace_len; c++) begin
         @(negedge CLK);
         drive_start(c == repulse_at);
         e    = exp_q.pop_front();
         mask = e[40] ? 32'hFFFF_FFFF : 32'h0;
         cmp(name, c, {1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 32'd0,
                       e[42], {4{e[41]}}, e[39:32], e[31:0] & mask}, mask);
         if (c == 1)   lit_di1   = cur_di;
         if (c == 258) lit_di258 = cur_di;
         if (c == abort_at) begin
            RST = 1'b1;
            @(negedge CLK);
            cmp({name, "_rst"}, c + 1, 91'd0, 32'hFFFF_FFFF);
            RST = 1'b0;
            return;
         end
      end
      for (int h = 0; h < 2; h++) begin
         @(negedge CLK);
         if (h == 0) done_cycle = trace_len + 1;
         cmp({name, "_done"}, trace_len + 1 + h,
             {1'b0, 1'b1, exp_fail, exp_elem, exp_addr, exp_data,
              1'b0, 4'h0, 8'h0, 32'h0}, 32'hFFFF_FFFF);
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int wr_base, rd_base, bad;
      repeat (3) @(negedge CLK);
      sel = 1'b0;
      cmp("reset_dut0", 0, 91'd0, 32'hFFFF_FFFF);
      sel = 1'b1;
      #1;
      cmp("reset_dut1", 0, 91'd0, 32'hFFFF_FFFF);
      sel = 1'b0;
      RST = 1'b0;
      @(negedge CLK);

      // fault-free pass with an ignored start pulse at cycle 500
      wr_base = wr_cnt;
      rd_base = rd_cnt;
      run_test("pass_repulse", 0, 0, 500);
      lit("pass_len", 64'(trace_len), 64'd2561);
      lit("pass_done_cycle", 64'(done_cycle), 64'd2562);
      lit("pass_writes", 64'(wr_cnt - wr_base), 64'd1280);
      lit("pass_reads", 64'(rd_cnt - rd_base), 64'd1280);

      // bit 5 of 0x3C stuck at 1
      run_test("stuck", 1, 0, 0);
      lit("stuck_done_cycle", 64'(done_cycle), 64'd379);
      lit("stuck_elem", 64'(cur_felem), 64'd1);
      lit("stuck_addr", 64'(cur_faddr), 64'h3C);
      lit("stuck_data", 64'(cur_fdata), 64'h0000_0020);

      // A0[7] ignored: restart from DONE after a failure
      run_test("alias", 2, 0, 0);
      lit("alias_done_cycle", 64'(done_cycle), 64'd515);
      lit("alias_elem", 64'(cur_felem), 64'd1);
      lit("alias_addr", 64'(cur_faddr), 64'h80);
      lit("alias_data", 64'(cur_fdata), 64'hFFFF_FFFF);

      // rerun after failure clears fail and passes
      run_test("rerun", 0, 0, 0);
      lit("rerun_fail", 64'(cur_fail), 64'd0);

      // RST mid-test, then a full pass
      run_test("abort", 0, 1000, 0);
      run_test("after_rst", 0, 0, 0);
      lit("after_rst_done_cycle", 64'(done_cycle), 64'd2562);

      // alternate background pattern on the second instance
      sel = 1'b1;
      run_test("pattern_a5", 0, 0, 0);
      lit("a5_m0_write", 64'(lit_di1), 64'hA5A5_A5A5);
      lit("a5_m1_write", 64'(lit_di258), 64'h5A5A_5A5A);
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem_1[i] !== PAT1) bad++;
      lit("a5_final_contents", 64'(bad), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
